rsa_mem_ctrl: RTL and testbench

RSA_MEM_CTRL -- requirements
Module: rsa_mem_ctrl

---
 rtl/rsa_pkg.sv | 10 +
 rtl/rsa_dpram.sv | 45 ++++
 rtl/rsa_mem_ctrl.sv | 135 +++++++++++++
 tb/tb_rsa_mem_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types for the RSA memory controller: run-control FSM state encoding.
package rsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rsaState_t;

endpackage

// File: rtl/rsa_dpram.sv
// Data memory: port A combinational read / sync write (CPU side),
// port B registered read / sync write with read-before-write (host side).
module rsa_dpram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              aWe,
  input  logic [ADDR_W-1:0] aAddr,
  input  logic [DATA_W-1:0] aWdata,
  output logic [DATA_W-1:0] aRdata,
  input  logic              bWe,
  input  logic              bRe,
  input  logic [ADDR_W-1:0] bAddr,
  input  logic [DATA_W-1:0] bWdata,
  output logic [DATA_W-1:0] bRdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] bRdataReg;

  assign aRdata = mem[aAddr];
  assign bRdata = bRdataReg;

  // The controller never enables both write ports in the same cycle.
  always_ff @(posedge clk) begin
    if (aWe) begin
      mem[aAddr] <= aWdata;
    end
    if (bWe) begin
      mem[bAddr] <= bWdata;
    end
  end

  // Only the output register is reset; the array contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bRdataReg <= '0;
    end else if (bRe) begin
      bRdataReg <= mem[bAddr];
    end
  end

endmodule

// File: rtl/rsa_mem_ctrl.sv
// Run controller for the RSA processor: owns the data memory, arbitrates host
// and CPU access by FSM state, and runs a watchdog cycle counter.
module rsa_mem_ctrl
  import rsa_pkg::*;
#(
  parameter  int DATA_W     = 32,
  parameter  int DEPTH      = 256,
  parameter  int MAX_CYCLES = 65535,
  localparam int ADDR_W     = $clog2(DEPTH),
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_start,
  input  logic              host_we,
  input  logic              host_re,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              cpu_start,
  input  logic              cpu_end,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              addr_err,
  output logic [CNT_W-1:0]  cycle_count
);

  rsaState_t         stateReg, stateNext;
  logic [CNT_W-1:0]  countReg, countNext, countInc;
  logic              timeoutReg, timeoutNext;
  logic              addrErrReg, addrErrNext;
  logic              rvalidReg;

  logic              inRun;
  logic              cpuInRange;
  logic              watchdogHit;
  logic [ADDR_W-1:0] cpuIndex;
  logic              memAWe, memBWe, memBRe;
  logic [DATA_W-1:0] memARdata;

  assign inRun      = (stateReg == RUN);
  assign cpuIndex   = cpu_addr[ADDR_W+1:2];
  assign cpuInRange = ((cpu_addr >> (ADDR_W + 2)) == '0);

  // The counter also advances on the exit cycle, so DONE reports the exact
  // number of RUN cycles; the watchdog fires when that count reaches the limit.
  assign countInc    = countReg + CNT_W'(1);
  assign watchdogHit = (countInc == CNT_W'(MAX_CYCLES));

  always_comb begin
    stateNext   = stateReg;
    countNext   = countReg;
    timeoutNext = timeoutReg;
    addrErrNext = addrErrReg;
    case (stateReg)
      IDLE, DONE: begin
        if (host_start) begin
          stateNext   = RUN;
          countNext   = '0;
          timeoutNext = 1'b0;
          addrErrNext = 1'b0;
        end
      end
      RUN: begin
        countNext = countInc;
        if (!cpuInRange) begin
          addrErrNext = 1'b1;
        end
        if (cpu_end) begin
          stateNext = DONE;
        end else if (watchdogHit) begin
          stateNext   = DONE;
          timeoutNext = 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateReg   <= IDLE;
      countReg   <= '0;
      timeoutReg <= 1'b0;
      addrErrReg <= 1'b0;
      rvalidReg  <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      countReg   <= countNext;
      timeoutReg <= timeoutNext;
      addrErrReg <= addrErrNext;
      rvalidReg  <= memBRe;
    end
  end

  // CPU owns the memory during RUN, the host owns it otherwise.
  assign memAWe = cpu_we && inRun && cpuInRange;
  assign memBWe = host_we && !inRun;
  assign memBRe = host_re && !inRun;

  rsa_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) uMem (
    .clk    (clk),
    .reset  (reset),
    .aWe    (memAWe),
    .aAddr  (cpuIndex),
    .aWdata (cpu_wdata),
    .aRdata (memARdata),
    .bWe    (memBWe),
    .bRe    (memBRe),
    .bAddr  (host_addr),
    .bWdata (host_wdata),
    .bRdata (host_rdata)
  );

  assign cpu_rdata   = cpuInRange ? memARdata : '0;
  assign cpu_start   = inRun;
  assign busy        = inRun;
  assign done        = (stateReg == DONE);
  assign timeout     = timeoutReg;
  assign addr_err    = addrErrReg;
  assign cycle_count = countReg;
  assign host_rvalid = rvalidReg;

endmodule

// File: tb/tb_rsa_mem_ctrl.sv
// Directed bench: default-sized controller for memory/run checks, plus a
// MAX_CYCLES=8 instance for the watchdog checks.
module tb_rsa_mem_ctrl;

  logic        clk;
  logic        reset;
  logic        hostStart, hostStartB;
  logic        hostWe, hostRe;
  logic [7:0]  hostAddr;
  logic [31:0] hostWdata;
  logic        cpuEnd, cpuEndB;
  logic        cpuWe;
  logic [31:0] cpuAddr, cpuWdata;

  logic [31:0] hostRdata, cpuRdata;
  logic        hostRvalid, cpuStart, busy, done, timeout, addrErr;
  logic [15:0] cycleCount;

  logic [31:0] hostRdataB, cpuRdataB;
  logic        hostRvalidB, cpuStartB, busyB, doneB, timeoutB, addrErrB;
  logic [3:0]  cycleCountB;

  int checks = 0;
  int errors = 0;

  rsa_mem_ctrl dut (
    .clk(clk), .reset(reset), .host_start(hostStart), .host_we(hostWe), .host_re(hostRe),
    .host_addr(hostAddr), .host_wdata(hostWdata), .host_rdata(hostRdata), .host_rvalid(hostRvalid),
    .cpu_start(cpuStart), .cpu_end(cpuEnd), .cpu_we(cpuWe), .cpu_addr(cpuAddr),
    .cpu_wdata(cpuWdata), .cpu_rdata(cpuRdata), .busy(busy), .done(done), .timeout(timeout),
    .addr_err(addrErr), .cycle_count(cycleCount)
  );

  rsa_mem_ctrl #(.MAX_CYCLES(8)) dutB (
    .clk(clk), .reset(reset), .host_start(hostStartB), .host_we(hostWe), .host_re(hostRe),
    .host_addr(hostAddr), .host_wdata(hostWdata), .host_rdata(hostRdataB), .host_rvalid(hostRvalidB),
    .cpu_start(cpuStartB), .cpu_end(cpuEndB), .cpu_we(cpuWe), .cpu_addr(cpuAddr),
    .cpu_wdata(cpuWdata), .cpu_rdata(cpuRdataB), .busy(busyB), .done(doneB), .timeout(timeoutB),
    .addr_err(addrErrB), .cycle_count(cycleCountB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("check %s ok: 0x%0h", tag, obs);
    end else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; hostStart = 1'b0; hostStartB = 1'b0; hostWe = 1'b0; hostRe = 1'b0;
    hostAddr = '0; hostWdata = '0; cpuEnd = 1'b0; cpuEndB = 1'b0; cpuWe = 1'b0;
    cpuAddr = '0; cpuWdata = '0;
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_cpu_start", {31'd0, cpuStart}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_addr_err", {31'd0, addrErr}, 32'd0);
    check("rst_rvalid", {31'd0, hostRvalid}, 32'd0);
    check("rst_rdata", hostRdata, 32'd0);
    check("rst_count", {16'd0, cycleCount}, 32'd0);
    reset = 1'b1;

    // Host preload and basic read.
    hostWe = 1'b1; hostAddr = 8'd0; hostWdata = 32'h11;
    tick();
    hostAddr = 8'd5; hostWdata = 32'hAB;
    tick();
    hostWe = 1'b0; hostRe = 1'b1; hostAddr = 8'd5;
    tick();
    hostRe = 1'b0;
    check("host_rd5_valid", {31'd0, hostRvalid}, 32'd1);
    check("host_rd5_data", hostRdata, 32'hAB);
    tick();
    check("host_rvalid_one_cycle", {31'd0, hostRvalid}, 32'd0);

    // Read-before-write on the same address.
    hostWe = 1'b1; hostRe = 1'b1; hostAddr = 8'd5; hostWdata = 32'h55;
    tick();
    hostWe = 1'b0; hostRe = 1'b0;
    check("rbw_old_data", hostRdata, 32'hAB);
    hostRe = 1'b1;
    tick();
    hostRe = 1'b0;
    check("rbw_new_data", hostRdata, 32'h55);

    // Write together with start; CPU sees it in the first RUN cycle.
    hostWe = 1'b1; hostAddr = 8'd6; hostWdata = 32'hCAFE; hostStart = 1'b1;
    tick();
    hostWe = 1'b0; hostStart = 1'b0; cpuAddr = 32'h18;
    #1;
    check("run_cpu_rd_new_word", cpuRdata, 32'hCAFE);
    check("run_busy", {31'd0, busy}, 32'd1);
    check("run_cpu_start", {31'd0, cpuStart}, 32'd1);
    check("run_count0", {16'd0, cycleCount}, 32'd0);
    cpuWe = 1'b1; cpuAddr = 32'h14; cpuWdata = 32'h1234;
    hostWe = 1'b1; hostRe = 1'b1; hostAddr = 8'd0; hostWdata = 32'hDEAD;
    tick();
    cpuWe = 1'b0; hostWe = 1'b0; hostRe = 1'b0;
    check("run_host_rvalid0", {31'd0, hostRvalid}, 32'd0);
    check("run_count1", {16'd0, cycleCount}, 32'd1);
    hostStart = 1'b1;
    #1;
    check("run_cpu_rd_written", cpuRdata, 32'h1234);
    tick();
    hostStart = 1'b0;
    check("run_start_ignored_busy", {31'd0, busy}, 32'd1);
    check("run_start_ignored_count", {16'd0, cycleCount}, 32'd2);
    repeat (7) tick();
    cpuEnd = 1'b1;
    tick();
    cpuEnd = 1'b0;
    check("end_done", {31'd0, done}, 32'd1);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_cpu_start", {31'd0, cpuStart}, 32'd0);
    check("end_count10", {16'd0, cycleCount}, 32'd10);
    check("end_timeout", {31'd0, timeout}, 32'd0);
    check("end_addr_err", {31'd0, addrErr}, 32'd0);
    hostRe = 1'b1; hostAddr = 8'd5;
    tick();
    check("done_rd5", hostRdata, 32'h1234);
    hostAddr = 8'd0;
    tick();
    hostRe = 1'b0;
    check("done_rd0_dropped_write", hostRdata, 32'h11);
    check("done_count_hold", {16'd0, cycleCount}, 32'd10);

    // Out-of-range CPU access.
    hostStart = 1'b1;
    tick();
    hostStart = 1'b0; cpuAddr = 32'h400; cpuWe = 1'b1; cpuWdata = 32'hBAD;
    #1;
    check("oor_cpu_rdata", cpuRdata, 32'd0);
    tick();
    cpuWe = 1'b0; cpuAddr = 32'h0;
    #1;
    check("oor_addr_err", {31'd0, addrErr}, 32'd1);
    check("oor_write_dropped", cpuRdata, 32'h11);
    cpuEnd = 1'b1;
    tick();
    cpuEnd = 1'b0;
    check("oor_sticky_done", {31'd0, addrErr}, 32'd1);
    hostStart = 1'b1;
    tick();
    hostStart = 1'b0;
    check("rerun_clears_addr_err", {31'd0, addrErr}, 32'd0);
    check("rerun_clears_count", {16'd0, cycleCount}, 32'd0);
    tick(); tick();

    // Reset mid-run keeps memory.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_cpu_start", {31'd0, cpuStart}, 32'd0);
    check("midrst_count", {16'd0, cycleCount}, 32'd0);
    hostRe = 1'b1; hostAddr = 8'd6;
    tick();
    hostRe = 1'b0;
    check("midrst_mem_kept", hostRdata, 32'hCAFE);
    cpuAddr = 32'h18; cpuWe = 1'b1; cpuWdata = 32'h999;
    tick();
    cpuWe = 1'b0;
    #1;
    check("idle_cpu_we_dropped", cpuRdata, 32'hCAFE);

    // Watchdog on the MAX_CYCLES=8 instance.
    cpuAddr = 32'h0;
    hostStartB = 1'b1;
    tick();
    hostStartB = 1'b0;
    check("wd_busy", {31'd0, busyB}, 32'd1);
    repeat (7) tick();
    check("wd_still_busy", {31'd0, busyB}, 32'd1);
    check("wd_count7", {28'd0, cycleCountB}, 32'd7);
    tick();
    check("wd_done", {31'd0, doneB}, 32'd1);
    check("wd_timeout", {31'd0, timeoutB}, 32'd1);
    check("wd_cpu_start", {31'd0, cpuStartB}, 32'd0);
    check("wd_count8", {28'd0, cycleCountB}, 32'd8);
    hostStartB = 1'b1;
    tick();
    hostStartB = 1'b0;
    check("wd_restart_timeout_clr", {31'd0, timeoutB}, 32'd0);
    repeat (7) tick();
    cpuEndB = 1'b1;
    tick();
    cpuEndB = 1'b0;
    check("wd_coincide_done", {31'd0, doneB}, 32'd1);
    check("wd_coincide_timeout", {31'd0, timeoutB}, 32'd0);
    check("wd_coincide_count", {28'd0, cycleCountB}, 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
